// File: rtl/alu_ctrl_stage.sv
// ALU control decode stage (RV32I, plus RV32M when ALU_MEXT_EN is defined) held in a one-entry pipeline register.
// Latency: 1 cycle for single-cycle ops; MUL_CYCLES/DIV_CYCLES cycles for M ops, with busy_o raised while waiting.
// Backpressure: ready_o is high when the stage is empty, or when it is full and execute takes the entry this cycle.
module alu_ctrl_stage #(
    parameter int CTRL_W     = 5,
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 8
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [1:0]        alu_op_i,
    input  logic [2:0]        funct3_i,
    input  logic              funct7_b5_i,
    input  logic              funct7_b0_i,
    input  logic              op_5_i,
    input  logic              flush_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [CTRL_W-1:0] alu_control_o,
    output logic              illegal_o,
    output logic              busy_o
);

    if (CTRL_W < 5 || MUL_CYCLES < 1 || DIV_CYCLES < 1) begin : g_param_check
        $error("alu_ctrl_stage: CTRL_W must be >= 5 and cycle counts >= 1");
    end

    localparam logic [4:0] C_ADD   = 5'd0;
    localparam logic [4:0] C_SUB   = 5'd1;
    localparam logic [4:0] C_AND   = 5'd2;
    localparam logic [4:0] C_OR    = 5'd3;
    localparam logic [4:0] C_XOR   = 5'd4;
    localparam logic [4:0] C_SLT   = 5'd5;
    localparam logic [4:0] C_SLTU  = 5'd6;
    localparam logic [4:0] C_SLL   = 5'd7;
    localparam logic [4:0] C_SRL   = 5'd8;
    localparam logic [4:0] C_SRA   = 5'd9;
    localparam logic [4:0] C_PASSB = 5'd10;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_WAIT  = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [4:0]        dec_code;
    logic              dec_ill;
    logic              dec_mext;
    logic              load;
    logic              accept;
    logic [CTRL_W-1:0] ctrl_q;
    logic              ill_q;

    always_comb begin
        dec_code = C_ADD;
        dec_ill  = 1'b0;
        dec_mext = 1'b0;
        case (alu_op_i)
            2'b00: dec_code = C_ADD;
            2'b11: dec_code = C_PASSB;
            2'b01: begin
                case (funct3_i)
                    3'b000, 3'b001: dec_code = C_SUB;
                    3'b100, 3'b101: dec_code = C_SLT;
                    3'b110, 3'b111: dec_code = C_SLTU;
                    default: begin
                        dec_code = C_ADD;
                        dec_ill  = 1'b1;
                    end
                endcase
            end
            default: begin
                case (funct3_i)
                    3'b000:  dec_code = (op_5_i & funct7_b5_i) ? C_SUB : C_ADD;
                    3'b001:  dec_code = C_SLL;
                    3'b010:  dec_code = C_SLT;
                    3'b011:  dec_code = C_SLTU;
                    3'b100:  dec_code = C_XOR;
                    3'b101:  dec_code = funct7_b5_i ? C_SRA : C_SRL;
                    3'b110:  dec_code = C_OR;
                    default: dec_code = C_AND;
                endcase
                // bit 30 is only meaningful on R-type ADD/SUB and on shifts-right
                if (op_5_i && funct7_b5_i && funct3_i != 3'b000 && funct3_i != 3'b101)
                    dec_ill = 1'b1;
                if (op_5_i && funct7_b0_i) begin
`ifdef ALU_MEXT_EN
                    dec_code = {2'b10, funct3_i};
                    dec_ill  = 1'b0;
                    dec_mext = 1'b1;
`else
                    dec_code = C_ADD;
                    dec_ill  = 1'b1;
`endif
                end
            end
        endcase
    end

    assign ready_o = (state_q == S_EMPTY) || ((state_q == S_FULL) && ready_i);
    assign accept  = valid_i && ready_o;
    assign valid_o = (state_q == S_FULL);

`ifdef ALU_MEXT_EN
    localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] wait_init;
    logic             dec_long;
    int               dec_lat;

    always_comb begin
        dec_lat   = funct3_i[2] ? DIV_CYCLES : MUL_CYCLES;
        dec_long  = dec_mext && (dec_lat > 1);
        wait_init = dec_long ? CNT_W'(dec_lat - 2) : '0;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        if (flush_i) begin
            state_d = S_EMPTY;
            cnt_d   = '0;
        end else if (accept) begin
            load    = 1'b1;
            state_d = dec_long ? S_WAIT : S_FULL;
            cnt_d   = wait_init;
        end else begin
            case (state_q)
                S_WAIT: begin
                    if (cnt_q == '0) state_d = S_FULL;
                    else             cnt_d   = cnt_q - 1'b1;
                end
                S_FULL: if (ready_i) state_d = S_EMPTY;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign busy_o = (state_q == S_WAIT);
`else
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        if (flush_i) begin
            state_d = S_EMPTY;
        end else if (accept) begin
            load    = 1'b1;
            state_d = S_FULL;
        end else if (state_q == S_FULL && ready_i) begin
            state_d = S_EMPTY;
        end
    end

    assign busy_o = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_EMPTY;
            ctrl_q  <= '0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load) begin
                ctrl_q <= CTRL_W'(dec_code);
                ill_q  <= dec_ill;
            end
        end
    end

    assign alu_control_o = ctrl_q;
    assign illegal_o     = ill_q;

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Scoreboard bench for alu_ctrl_stage: decode table, stalls, flush and asynchronous reset.
module tb_alu_ctrl_stage;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       valid_i, ready_i, flush_i;
    logic [1:0] alu_op;
    logic [2:0] funct3;
    logic       f7b5, f7b0, op5;
    logic       ready_o, valid_o, illegal_o, busy_o;
    logic [4:0] alu_control;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [4:0] code;
        logic       ill;
    } exp_t;

    typedef struct {
        logic [1:0] aop;
        logic [2:0] f3;
        logic       b5, b0, o5;
        logic [4:0] code;
        logic       ill;
    } vec_t;

    exp_t sb[$];

    alu_ctrl_stage #(.CTRL_W(5), .MUL_CYCLES(2), .DIV_CYCLES(8)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid_i), .ready_o(ready_o),
        .alu_op_i(alu_op), .funct3_i(funct3), .funct7_b5_i(f7b5), .funct7_b0_i(f7b0),
        .op_5_i(op5), .flush_i(flush_i), .valid_o(valid_o), .ready_i(ready_i),
        .alu_control_o(alu_control), .illegal_o(illegal_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic drive(input logic v, input logic [1:0] aop, input logic [2:0] f3,
                         input logic b5, input logic b0, input logic o5,
                         input logic ri, input logic fl);
        valid_i = v; alu_op = aop; funct3 = f3; f7b5 = b5; f7b0 = b0; op5 = o5;
        ready_i = ri; flush_i = fl;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        drive(0, 2'b00, 3'b000, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", ready_o); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
        checks++; if (alu_control !== 5'd0) begin errors++; $display("FAIL reset_ctrl got=%0d exp=0", alu_control); end
        checks++; if (illegal_o !== 1'b0) begin errors++; $display("FAIL reset_illegal got=%b exp=0", illegal_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    endtask

    task automatic test_decode_stream;
        vec_t tbl[$];
        exp_t e;
        int   n, npop;
        tbl.push_back('{2'b10, 3'b000, 1'b1, 1'b0, 1'b1, 5'd1,  1'b0});
        tbl.push_back('{2'b10, 3'b000, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0});
        tbl.push_back('{2'b10, 3'b101, 1'b1, 1'b0, 1'b0, 5'd9,  1'b0});
        tbl.push_back('{2'b10, 3'b101, 1'b0, 1'b0, 1'b1, 5'd8,  1'b0});
        tbl.push_back('{2'b10, 3'b101, 1'b1, 1'b0, 1'b1, 5'd9,  1'b0});
        tbl.push_back('{2'b10, 3'b001, 1'b0, 1'b0, 1'b1, 5'd7,  1'b0});
        tbl.push_back('{2'b10, 3'b010, 1'b0, 1'b0, 1'b0, 5'd5,  1'b0});
        tbl.push_back('{2'b10, 3'b011, 1'b0, 1'b0, 1'b1, 5'd6,  1'b0});
        tbl.push_back('{2'b10, 3'b100, 1'b0, 1'b0, 1'b1, 5'd4,  1'b0});
        tbl.push_back('{2'b10, 3'b110, 1'b0, 1'b0, 1'b0, 5'd3,  1'b0});
        tbl.push_back('{2'b10, 3'b111, 1'b0, 1'b0, 1'b1, 5'd2,  1'b0});
        tbl.push_back('{2'b10, 3'b001, 1'b1, 1'b0, 1'b1, 5'd7,  1'b1});
        tbl.push_back('{2'b10, 3'b110, 1'b1, 1'b0, 1'b1, 5'd3,  1'b1});
        tbl.push_back('{2'b10, 3'b001, 1'b1, 1'b0, 1'b0, 5'd7,  1'b0});
        tbl.push_back('{2'b10, 3'b000, 1'b0, 1'b1, 1'b0, 5'd0,  1'b0});
        tbl.push_back('{2'b00, 3'b111, 1'b1, 1'b1, 1'b1, 5'd0,  1'b0});
        tbl.push_back('{2'b11, 3'b010, 1'b0, 1'b0, 1'b0, 5'd10, 1'b0});
        tbl.push_back('{2'b01, 3'b110, 1'b0, 1'b0, 1'b0, 5'd6,  1'b0});
        tbl.push_back('{2'b01, 3'b010, 1'b0, 1'b0, 1'b0, 5'd0,  1'b1});
        tbl.push_back('{2'b01, 3'b000, 1'b0, 1'b0, 1'b0, 5'd1,  1'b0});
        tbl.push_back('{2'b01, 3'b001, 1'b0, 1'b0, 1'b0, 5'd1,  1'b0});
        tbl.push_back('{2'b01, 3'b100, 1'b0, 1'b0, 1'b0, 5'd5,  1'b0});
        tbl.push_back('{2'b01, 3'b101, 1'b0, 1'b0, 1'b0, 5'd5,  1'b0});
        tbl.push_back('{2'b01, 3'b111, 1'b0, 1'b0, 1'b0, 5'd6,  1'b0});
        tbl.push_back('{2'b01, 3'b011, 1'b0, 1'b0, 1'b0, 5'd0,  1'b1});
`ifndef ALU_MEXT_EN
        tbl.push_back('{2'b10, 3'b100, 1'b0, 1'b1, 1'b1, 5'd0,  1'b1});
        tbl.push_back('{2'b10, 3'b000, 1'b0, 1'b1, 1'b1, 5'd0,  1'b1});
`endif
        n    = tbl.size();
        npop = 0;
        for (int cyc = 0; cyc < n + 2; cyc++) begin
            @(negedge clk);
            if (cyc < n) drive(1, tbl[cyc].aop, tbl[cyc].f3, tbl[cyc].b5, tbl[cyc].b0, tbl[cyc].o5, 1, 0);
            else         drive(0, 2'b00, 3'b000, 0, 0, 0, 1, 0);
            #1;
            if (cyc >= 1 && cyc <= n) begin
                checks++;
                if (valid_o !== 1'b1) begin errors++; $display("FAIL stream_throughput cyc=%0d valid got=%b exp=1", cyc, valid_o); end
            end
            if (valid_o && ready_i) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++; $display("FAIL stream_unexpected_output code=%0d", alu_control);
                end else begin
                    e = sb.pop_front();
                    npop++;
                    if (alu_control !== e.code || illegal_o !== e.ill) begin
                        errors++;
                        $display("FAIL stream_decode item=%0d got code=%0d ill=%b exp code=%0d ill=%b",
                                 npop - 1, alu_control, illegal_o, e.code, e.ill);
                    end
                end
            end
            if (cyc < n && ready_o) sb.push_back('{tbl[cyc].code, tbl[cyc].ill});
        end
        checks++; if (npop != n) begin errors++; $display("FAIL stream_count got=%0d exp=%0d", npop, n); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL stream_drain valid got=%b exp=0", valid_o); end
        sb.delete();
    endtask

    task automatic test_back_to_back;
        exp_t e;
        @(negedge clk);
        drive(1, 2'b10, 3'b100, 0, 0, 1, 0, 0);
        #1;
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL b2b_first_ready got=%b exp=1", ready_o); end
        sb.push_back('{5'd4, 1'b0});
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(1, 2'b10, 3'b110, 0, 0, 1, 0, 0);
            #1;
            checks++;
            if (ready_o !== 1'b0 || valid_o !== 1'b1 || alu_control !== 5'd4) begin
                errors++;
                $display("FAIL b2b_stall k=%0d got ready=%b valid=%b code=%0d exp ready=0 valid=1 code=4",
                         k, ready_o, valid_o, alu_control);
            end
        end
        @(negedge clk);
        drive(1, 2'b10, 3'b110, 0, 0, 1, 1, 0);
        #1;
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL b2b_release_ready got=%b exp=1", ready_o); end
        e = sb.pop_front();
        checks++;
        if (alu_control !== e.code) begin errors++; $display("FAIL b2b_first_code got=%0d exp=%0d", alu_control, e.code); end
        if (ready_o) sb.push_back('{5'd3, 1'b0});
        @(negedge clk);
        drive(0, 2'b00, 3'b000, 0, 0, 0, 1, 0);
        #1;
        checks++;
        if (sb.size() == 0 || valid_o !== 1'b1) begin
            errors++; $display("FAIL b2b_second_valid got=%b exp=1", valid_o);
        end else begin
            e = sb.pop_front();
            if (alu_control !== e.code) begin errors++; $display("FAIL b2b_second_code got=%0d exp=%0d", alu_control, e.code); end
        end
        @(negedge clk);
        #1;
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL b2b_empty valid got=%b exp=0", valid_o); end
        sb.delete();
    endtask

    task automatic test_flush;
        @(negedge clk);
        drive(1, 2'b10, 3'b111, 0, 0, 1, 0, 0);
        @(negedge clk);
        drive(1, 2'b10, 3'b100, 0, 0, 1, 1, 1);
        #1;
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL flush_ready got=%b exp=1", ready_o); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(0, 2'b00, 3'b000, 0, 0, 0, 1, 0);
            #1;
            checks++;
            if (valid_o !== 1'b0 || busy_o !== 1'b0 || ready_o !== 1'b1) begin
                errors++;
                $display("FAIL flush_dropped k=%0d got valid=%b busy=%b ready=%b exp 0 0 1", k, valid_o, busy_o, ready_o);
            end
        end
`ifdef ALU_MEXT_EN
        @(negedge clk);
        drive(1, 2'b10, 3'b100, 0, 1, 1, 1, 0);
        @(negedge clk);
        drive(0, 2'b00, 3'b000, 0, 0, 0, 1, 0);
        @(negedge clk);
        #1;
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL flush_wait_busy got=%b exp=1", busy_o); end
        drive(1, 2'b10, 3'b000, 0, 0, 1, 1, 1);
        @(negedge clk);
        drive(0, 2'b00, 3'b000, 0, 0, 0, 1, 0);
        #1;
        checks++;
        if (valid_o !== 1'b0 || busy_o !== 1'b0 || ready_o !== 1'b1) begin
            errors++;
            $display("FAIL flush_wait got valid=%b busy=%b ready=%b exp 0 0 1", valid_o, busy_o, ready_o);
        end
        @(negedge clk);
        #1;
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL flush_wait_dropped valid got=%b exp=0", valid_o); end
`endif
    endtask

`ifdef ALU_MEXT_EN
    task automatic test_mext;
        exp_t e;
        @(negedge clk);
        drive(1, 2'b10, 3'b100, 0, 1, 1, 1, 0);
        #1;
        if (ready_o) sb.push_back('{5'd20, 1'b0});
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            drive(0, 2'b00, 3'b000, 0, 0, 0, 1, 0);
            #1;
            checks++;
            if (busy_o !== 1'b1 || ready_o !== 1'b0 || valid_o !== 1'b0) begin
                errors++;
                $display("FAIL div_wait k=%0d got busy=%b ready=%b valid=%b exp 1 0 0", k, busy_o, ready_o, valid_o);
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if (valid_o !== 1'b1 || busy_o !== 1'b0 || sb.size() == 0) begin
            errors++; $display("FAIL div_done got valid=%b busy=%b exp valid=1 busy=0", valid_o, busy_o);
        end else begin
            e = sb.pop_front();
            if (alu_control !== e.code) begin errors++; $display("FAIL div_code got=%0d exp=%0d", alu_control, e.code); end
        end
        @(negedge clk);
        drive(1, 2'b10, 3'b000, 0, 1, 1, 1, 0);
        @(negedge clk);
        drive(0, 2'b00, 3'b000, 0, 0, 0, 1, 0);
        #1;
        checks++; if (busy_o !== 1'b1 || valid_o !== 1'b0) begin errors++; $display("FAIL mul_wait got busy=%b valid=%b exp 1 0", busy_o, valid_o); end
        @(negedge clk);
        #1;
        checks++;
        if (valid_o !== 1'b1 || alu_control !== 5'd16) begin
            errors++; $display("FAIL mul_done got valid=%b code=%0d exp valid=1 code=16", valid_o, alu_control);
        end
        @(negedge clk);
        drive(0, 2'b00, 3'b000, 0, 0, 0, 1, 0);
        sb.delete();
    endtask
`endif

    task automatic test_async_reset;
        @(negedge clk);
`ifdef ALU_MEXT_EN
        drive(1, 2'b10, 3'b101, 0, 1, 1, 0, 0);
        @(negedge clk);
        drive(0, 2'b00, 3'b000, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL areset_pre busy got=%b exp=1", busy_o); end
`else
        drive(1, 2'b10, 3'b110, 1, 0, 1, 0, 0);
        @(negedge clk);
        drive(0, 2'b00, 3'b000, 0, 0, 0, 0, 0);
        #1;
        checks++;
        if (valid_o !== 1'b1 || alu_control !== 5'd3 || illegal_o !== 1'b1) begin
            errors++;
            $display("FAIL areset_pre got valid=%b code=%0d ill=%b exp 1 3 1", valid_o, alu_control, illegal_o);
        end
`endif
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (valid_o !== 1'b0 || alu_control !== 5'd0 || illegal_o !== 1'b0 || busy_o !== 1'b0 || ready_o !== 1'b1) begin
            errors++;
            $display("FAIL areset got valid=%b code=%0d ill=%b busy=%b ready=%b exp 0 0 0 0 1",
                     valid_o, alu_control, illegal_o, busy_o, ready_o);
        end
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        checks++; if (valid_o !== 1'b0 || ready_o !== 1'b1) begin errors++; $display("FAIL areset_after got valid=%b ready=%b exp 0 1", valid_o, ready_o); end
    endtask

    initial begin
        test_reset();
        test_decode_stream();
        test_back_to_back();
        test_flush();
`ifdef ALU_MEXT_EN
        test_mext();
`endif
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_stage.md
# alu_ctrl_stage

Registered, parametrised successor to the combinational ALU decoder. It decodes the full RV32I ALU operation set, and optionally RV32M, into a wide ALU control code held in a single-entry pipeline register with valid/ready handshakes. It sits between the decode and execute stages of the pipelined core. For multi-cycle M-extension ops it withholds `valid_o` for a configurable latency and raises `busy_o` to the hazard unit.

## Interface
Parameters:
- `CTRL_W`, default 5: width of `alu_control_o`; must be at least 5.
- `MUL_CYCLES`, default 2: execute latency of MUL* ops, in cycles (≥1).
- `DIV_CYCLES`, default 8: execute latency of DIV*/REM* ops, in cycles (≥1).

Ports:
- `clk_i` in 1: clock; all state updates on the rising edge.
- `rst_n_i` in 1: asynchronous, active-low reset.
- `valid_i` in 1: decode stage offers an instruction.
- `ready_o` out 1: stage accepts this cycle.
- `alu_op_i` in 2: 00 load/store, 01 branch, 10 R/I-type, 11 LUI.
- `funct3_i` in 3: instruction funct3.
- `funct7_b5_i` in 1: instruction bit 30.
- `funct7_b0_i` in 1: instruction bit 25 (M-extension select).
- `op_5_i` in 1: opcode bit 5 (1 = R-type, 0 = I-type).
- `flush_i` in 1: synchronous kill of the held entry.
- `valid_o` out 1: `alu_control_o` is valid for execute.
- `ready_i` in 1: execute consumes this cycle.
- `alu_control_o` out CTRL_W: registered ALU control code.
- `illegal_o` out 1: held entry is an undefined encoding; qualified by `valid_o`.
- `busy_o` out 1: a multi-cycle op is in progress.

## Operation
Control encoding (zero-extended to CTRL_W):
- 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA, 10 PASSB.
- 16 MUL, 17 MULH, 18 MULHSU, 19 MULHU, 20 DIV, 21 DIVU, 22 REM, 23 REMU.

Decode by `alu_op_i`:
- 00 → ADD.
- 11 → PASSB.
- 01 → by `funct3_i`:
  - 000/001 → SUB.
  - 100/101 → SLT.
  - 110/111 → SLTU.
  - 010/011 → ADD with `illegal_o`=1.
- 10 → by `funct3_i`:
  - 000 → SUB when `op_5_i`&`funct7_b5_i`, else ADD.
  - 001 → SLL.
  - 010 → SLT.
  - 011 → SLTU.
  - 100 → XOR.
  - 101 → SRA when `funct7_b5_i` (regardless of `op_5_i`), else SRL.
  - 110 → OR.
  - 111 → AND.
  - `funct7_b5_i`=1 with `op_5_i`=1 and `funct3_i` ∉ {000,101} → `illegal_o`=1.
- R-type (`op_5_i`=1) with `funct7_b0_i`=1: with the macro enabled, code = 16 + `funct3_i`; without it, ADD with `illegal_o`=1.

State machine, states EMPTY, WAIT, FULL:
- `ready_o` = (state==EMPTY) | (state==FULL & `ready_i`). It is combinational and is low in WAIT.
- Accept (`valid_i`&`ready_o`):
  - Registers the decode.
  - Single-cycle op, or latency of 1 → FULL.
  - Multi-cycle op with latency L>1 → WAIT with counter = L−2.
- WAIT:
  - Counter decrements each cycle.
  - At counter 0 → FULL on the next edge.
  - `busy_o`=1 throughout WAIT.
- FULL with `ready_i`: consumed. If a new accept occurs in the same cycle, the new entry is loaded back-to-back; otherwise → EMPTY.
- `flush_i` has priority over everything:
  - Next state EMPTY; counter cleared.
  - Any simultaneous `valid_i` is dropped.
  - `ready_o` stays as computed, but the accept is ignored.
- Counter width is `$clog2(max(MUL_CYCLES,DIV_CYCLES))+1`; the counter never wraps.

## Timing
- Reset (asynchronous, any state, including mid-WAIT): state EMPTY, counter 0, `valid_o`=0, `alu_control_o`=0, `illegal_o`=0, `busy_o`=0, `ready_o`=1.
- Single-cycle op: accepted at edge N, `valid_o`=1 after edge N.
- Multi-cycle op with latency L: `valid_o`=1 after edge N+L−1; `busy_o`=1 after edges N … N+L−2.
- Throughput is one single-cycle op per clock while `ready_i`=1.
- Outputs are stable while `valid_o`=1 and `ready_i`=0.

## Configuration
- `ALU_MEXT_EN` defined: RV32M decode, codes 16–23, the WAIT state and counter, and `busy_o` are all built.
- `ALU_MEXT_EN` undefined:
  - `funct7_b0_i`=1 R-type is flagged illegal.
  - The WAIT state and counter are omitted.
  - `busy_o` is tied to 0.
  - `MUL_CYCLES`/`DIV_CYCLES` are ignored.

## Test plan
- Reset then idle → `ready_o`=1, `valid_o`=0, `alu_control_o`=0; assert `rst_n_i` low mid-WAIT → all outputs cleared immediately, without waiting for a clock edge.
- Stream `alu_op_i`=10 with `op_5_i`=1, `funct7_b5_i`=1, `funct3_i`=000, then the same with `op_5_i`=0, then `funct3_i`=101 with `op_5_i`=0, `funct7_b5_i`=1, all with `ready_i`=1 → codes 1, 0, 9 on consecutive cycles.
- Branch `funct3_i`=110 → 6; `funct3_i`=010 → 0 with `illegal_o`=1.
- With `ALU_MEXT_EN` and DIV_CYCLES=8, send DIV (`funct3_i`=100, `funct7_b0_i`=1) → `busy_o` high for 7 cycles, `ready_o` low, then `valid_o`=1 with code 20.
- Hold `ready_i`=0 with FULL → `alu_control_o` stable and `ready_o`=0; release → consumed with back-to-back accept.
- `flush_i` during WAIT with simultaneous `valid_i` → EMPTY next cycle, `valid_o`=0, `busy_o`=0, new op dropped.
